pic_fetch_unit: RTL and testbench
=================================

// Module: pic_fetch_unit
// PURPOSE
// Fetch end of the PIC16F core: owns the Q1-Q4 phase counter, 13-bit program counter, prefetch and instruction regs, 8-level call stack.
// Reads program memory, presents instr_current to the instruction decoder, applies decoder PC controls at Q4.
// Taken branches/skips replace the prefetched word with a NOP, so they cost 8 clocks; all other instructions cost 4.
// PARAMETERS
// PC_W      13   program counter / program memory address width
// INSTR_W   14   instruction word width
// STACK_D   8    hardware call-stack depth (power of 2)
// PORTS
// clk          in   1        core clock
// rst          in   1        asynchronous, active-high reset
// pmem_addr    out  PC_W     program memory address (= pc)
// pmem_rd_en   out  1        read strobe, high in Q1 only
// pmem_data    in   INSTR_W  program memory word, valid the clock after pmem_rd_en
// instr_current out INSTR_W  instruction register to decoder
// q_phase      out  2        0..3 = Q1..Q4
// pc           out  PC_W     current program counter
// incr_pc_en   in   1        advance pipeline this instruction cycle (0 = stall)
// jump_en      in   1        GOTO
// call_en      in   1        CALL (push return address, then jump)
// ret_en       in   1        RETURN/RETLW/RETFIE (pop into pc)
// pcl_wr_en    in   1        write to PCL (computed goto)
// skip_en      in   1        conditional skip taken: discard prefetch
// jump_lit     in   11       GOTO/CALL literal
// pcl_wr_data  in   8        new PCL value
// pclath       in   5        PCLATH register
// BEHAVIOUR
// Reset (async, immediate): q_phase=0, pc=0, instr_current=14'h0000 (NOP), prefetch=0, stack_ptr=0, stack entries=0.
// - pmem_rd_en=0 while rst high.
// q_phase free-runs 0,1,2,3,0... every clk; never stalls.
// pmem_rd_en = (q_phase==0), combinational; pmem_addr = pc.
// prefetch <= pmem_data at the edge ending Q2 (q_phase==1); sync ROM with 1-clk latency.
// Decoder controls are sampled ONLY at the edge ending Q4 (q_phase==3); they are ignored in other phases.
// At the Q4 edge, priority ret_en > call_en > jump_en > pcl_wr_en > skip_en > incr_pc_en:
// - ret_en:    pc <= stack[ptr-1]; ptr <= ptr-1; redirect.
// - call_en:   stack[ptr] <= pc; ptr <= ptr+1; pc <= {pclath[4:3], jump_lit}; redirect.
// - jump_en:   pc <= {pclath[4:3], jump_lit}; redirect.
// - pcl_wr_en: pc <= {pclath, pcl_wr_data}; redirect.
// - skip_en:   pc <= pc+1; redirect.
// - incr_pc_en only: pc <= pc+1; instr_current <= prefetch.
// - none asserted: stall; pc and instr_current hold.
// Redirect: instr_current <= 14'h0000 at the same Q4 edge (forced NOP); new pc is fetched in the following Q1.
// pc is always the prefetch address (= executing address + 1), so CALL pushes the correct return address.
// pc+1 wraps 13'h1FFF -> 13'h0000.
// Stack is circular, 3-bit pointer wraps mod STACK_D; no overflow/underflow flags.
// - 9th push overwrites oldest entry; pop on empty returns wrapped entry.
// First instruction cycle after reset executes NOP while address 0 is fetched.
// Assertion-level rst mid-cycle aborts everything; no partial update survives.
// STRUCTURE
// pic_pkg: PC_W/INSTR_W constants, NOP = 14'h0000, Q-phase localparams Q1..Q4.
// Sub-module pic_call_stack: STACK_D x PC_W regs with push/pop/top and wrapping pointer.
// Q counter, pc, prefetch and instr regs stay in pic_fetch_unit.
// TESTING
// Straight-line run: pmem model returns {1'b1,addr}; incr_pc_en=1 -> instr_current 0 for 4 clks, then 0x2000, 0x2001...; pmem_addr 0,1,2 at Q1.
// GOTO: at Q4 with pc=0x006, jump_en=1, jump_lit=0x123, pclath=5'b10000 -> pc=0x1123, next 4 clks NOP, then word@0x1123.
// CALL/RETURN: pc=0x005, call lit=0x040 -> pc=0x040; later ret_en -> pc=0x005; each followed by one NOP slot.
// Stack wrap: 9 CALLs returning p1..p9 then 9 RETURNs -> pops p9,p8..p2, then p9.
// Boundaries: pc=0x1FFF incr -> 0x0000; pcl_wr_data=0x80, pclath=0x1F -> pc=0x1F80; skip_en -> pc+1 with NOP; controls outside Q4 ignored.
// Async rst pulse mid-Q2 -> q_phase, pc, instr_current 0 immediately, before next clk edge.

Source files
------------

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared constants and types for the PIC16F fetch end.
//   PC_W / INSTR_W / STACK_D : default widths and stack depth
//   NOP                      : instruction word forced in on a redirect
//   Q1..Q4                   : q_phase encodings
//   pc_op_e / decode_pc_op   : prioritised decoder PC control
// ---------------------------------------------------------------------------
package pic_pkg;

    localparam int PC_W    = 13;
    localparam int INSTR_W = 14;
    localparam int STACK_D = 8;

    localparam logic [INSTR_W-1:0] NOP = '0;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INCR,
        PC_SKIP,
        PC_PCL,
        PC_JUMP,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Highest priority first: ret > call > jump > pcl write > skip > incr.
    function automatic pc_op_e decode_pc_op(
        input logic ret_en,
        input logic call_en,
        input logic jump_en,
        input logic pcl_wr_en,
        input logic skip_en,
        input logic incr_pc_en
    );
        if (ret_en)          return PC_RET;
        else if (call_en)    return PC_CALL;
        else if (jump_en)    return PC_JUMP;
        else if (pcl_wr_en)  return PC_PCL;
        else if (skip_en)    return PC_SKIP;
        else if (incr_pc_en) return PC_INCR;
        else                 return PC_HOLD;
    endfunction

endpackage

// File: rtl/pic_call_stack.sv
// ---------------------------------------------------------------------------
// pic_call_stack
// Circular hardware call stack. No overflow/underflow detection: a push
// beyond DEPTH overwrites the oldest entry, a pop on empty wraps.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : store push_data_i at ptr, ptr+1
//   pop_i        : ptr-1 (top_o is the value being popped)
//   push_data_i  : return address to store
//   top_o        : entry at ptr-1
// ---------------------------------------------------------------------------
module pic_call_stack
    import pic_pkg::*;
#(
    parameter int DEPTH = STACK_D,
    parameter int WIDTH = PC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] top_idx;

    // Pointer arithmetic wraps naturally at PTR_W bits (DEPTH is a power of 2).
    assign top_idx = ptr_q - PTR_W'(1);
    assign top_o   = entry_q[top_idx];

    // NOTE: the stack entries are reset along with the pointer so a pop on an
    // empty stack returns a defined value; the array is small enough that
    // this is a register bank, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (push_i) begin
            entry_q[ptr_q] <= push_data_i;
            ptr_q          <= ptr_q + PTR_W'(1);
        end else if (pop_i) begin
            ptr_q <= top_idx;
        end
    end

endmodule

// File: rtl/pic_fetch_unit.sv
// ---------------------------------------------------------------------------
// pic_fetch_unit
// Fetch end of the PIC16F core: Q1-Q4 phase counter, program counter,
// prefetch and instruction registers, 8-level call stack.
//   clk, rst       : clock, asynchronous active-high reset
//   pmem_addr      : program memory address (= pc)
//   pmem_rd_en     : read strobe, Q1 only
//   pmem_data      : program word, valid the clock after pmem_rd_en
//   instr_current  : instruction register to the decoder
//   q_phase        : 0..3 = Q1..Q4
//   pc             : program counter (address of the prefetched word)
//   incr_pc_en, jump_en, call_en, ret_en, pcl_wr_en, skip_en,
//   jump_lit, pcl_wr_data, pclath : decoder PC controls, sampled at Q4 only
// Every change of flow (ret/call/jump/pcl/skip) discards the prefetched
// word by loading a NOP, so those instructions take two instruction cycles.
// ---------------------------------------------------------------------------
module pic_fetch_unit
    import pic_pkg::*;
#(
    parameter int PC_W    = pic_pkg::PC_W,
    parameter int INSTR_W = pic_pkg::INSTR_W,
    parameter int STACK_D = pic_pkg::STACK_D
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    pmem_addr,
    output logic               pmem_rd_en,
    input  logic [INSTR_W-1:0] pmem_data,
    output logic [INSTR_W-1:0] instr_current,
    output logic [1:0]         q_phase,
    output logic [PC_W-1:0]    pc,
    input  logic               incr_pc_en,
    input  logic               jump_en,
    input  logic               call_en,
    input  logic               ret_en,
    input  logic               pcl_wr_en,
    input  logic               skip_en,
    input  logic [10:0]        jump_lit,
    input  logic [7:0]         pcl_wr_data,
    input  logic [4:0]         pclath
);

    logic [1:0]         q_q;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] prefetch_q;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    stack_top;
    logic               is_q4;
    pc_op_e             pc_op;

    assign is_q4  = (q_q == Q4);
    assign pc_op  = decode_pc_op(ret_en, call_en, jump_en, pcl_wr_en, skip_en, incr_pc_en);
    assign pc_inc = pc_q + PC_W'(1);

    pic_call_stack #(
        .DEPTH (STACK_D),
        .WIDTH (PC_W)
    ) u_call_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (is_q4 && (pc_op == PC_CALL)),
        .pop_i       (is_q4 && (pc_op == PC_RET)),
        .push_data_i (pc_q),
        .top_o       (stack_top)
    );

    // NOTE: every signal assigned in an always_comb block gets a default
    // first, so no path through the case can leave it unassigned (latch).
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (is_q4) begin
            case (pc_op)
                PC_RET:  begin pc_d = stack_top;                  instr_d = NOP; end
                PC_CALL: begin pc_d = {pclath[4:3], jump_lit};    instr_d = NOP; end
                PC_JUMP: begin pc_d = {pclath[4:3], jump_lit};    instr_d = NOP; end
                PC_PCL:  begin pc_d = {pclath, pcl_wr_data};      instr_d = NOP; end
                PC_SKIP: begin pc_d = pc_inc;                     instr_d = NOP; end
                PC_INCR: begin pc_d = pc_inc;                     instr_d = prefetch_q; end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= Q1;
            pc_q       <= '0;
            instr_q    <= NOP;
            prefetch_q <= NOP;
        end else begin
            q_q     <= q_q + 2'd1;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            // Memory was read in Q1; its word is on pmem_data during Q2.
            if (q_q == Q2) begin
                prefetch_q <= pmem_data;
            end
        end
    end

    assign q_phase       = q_q;
    assign pc            = pc_q;
    assign pmem_addr     = pc_q;
    assign instr_current = instr_q;
    assign pmem_rd_en    = (q_q == Q1) && !rst;

endmodule

// File: tb/tb_pic_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pic_fetch_unit
// Table-driven instruction-cycle vectors plus hand-written sequences for
// controls outside Q4, stack wrap-around and asynchronous reset.
// Program memory model returns {1'b1, addr} one clock after the read strobe.
// ---------------------------------------------------------------------------
module tb_pic_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] pmem_addr;
    logic        pmem_rd_en;
    logic [13:0] pmem_data = '0;
    logic [13:0] instr_current;
    logic [1:0]  q_phase;
    logic [12:0] pc;
    logic        incr_pc_en = 0, jump_en = 0, call_en = 0, ret_en = 0;
    logic        pcl_wr_en = 0, skip_en = 0;
    logic [10:0] jump_lit = '0;
    logic [7:0]  pcl_wr_data = '0;
    logic [4:0]  pclath = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pic_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pmem_addr     (pmem_addr),
        .pmem_rd_en    (pmem_rd_en),
        .pmem_data     (pmem_data),
        .instr_current (instr_current),
        .q_phase       (q_phase),
        .pc            (pc),
        .incr_pc_en    (incr_pc_en),
        .jump_en       (jump_en),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .pcl_wr_en     (pcl_wr_en),
        .skip_en       (skip_en),
        .jump_lit      (jump_lit),
        .pcl_wr_data   (pcl_wr_data),
        .pclath        (pclath)
    );

    always @(posedge clk) begin
        if (pmem_rd_en) pmem_data <= {1'b1, pmem_addr};
    end

    typedef struct {
        logic [5:0]  ctl;      // {ret, call, jump, pcl, skip, incr}
        logic [10:0] lit;
        logic [7:0]  data;
        logic [4:0]  pclath;
        logic [12:0] exp_pc;
        logic [13:0] exp_instr;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic [5:0] ctl, input logic [10:0] lit,
                                input logic [7:0] data, input logic [4:0] lath,
                                input logic [12:0] epc, input logic [13:0] ein);
        vec_t v;
        v.ctl = ctl; v.lit = lit; v.data = data; v.pclath = lath;
        v.exp_pc = epc; v.exp_instr = ein;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bounded wait (at negedges) for a given phase.
    task automatic wait_phase(input logic [1:0] target);
        int n = 0;
        while (q_phase !== target && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (q_phase !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: q_phase 0x%0h never reached 0x%0h", q_phase, target);
        end
    endtask

    // Drive one vector into Q4, cross the Q4 edge, check results in Q1.
    task automatic do_cycle(input vec_t v, input string tag);
        wait_phase(2'd3);
        {ret_en, call_en, jump_en, pcl_wr_en, skip_en, incr_pc_en} = v.ctl;
        jump_lit = v.lit; pcl_wr_data = v.data; pclath = v.pclath;
        @(posedge clk);
        @(negedge clk);
        {ret_en, call_en, jump_en, pcl_wr_en, skip_en, incr_pc_en} = '0;
        check({tag, " q_phase"}, 32'(q_phase), 32'd0);
        check({tag, " pc"}, 32'(pc), 32'(v.exp_pc));
        check({tag, " instr"}, 32'(instr_current), 32'(v.exp_instr));
        check({tag, " rd_en"}, 32'(pmem_rd_en), 32'd1);
        check({tag, " addr"}, 32'(pmem_addr), 32'(v.exp_pc));
    endtask

    initial begin
        //                 ctl       lit     data   pclath  pc        instr
        tbl[0]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0001, 14'h2000);
        tbl[1]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0002, 14'h2001);
        tbl[2]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0003, 14'h2002);
        tbl[3]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0004, 14'h2003);
        tbl[4]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0005, 14'h2004);
        tbl[5]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0006, 14'h2005);
        tbl[6]  = mk(6'b001000, 11'h123, 8'h00, 5'h10, 13'h1123, 14'h0000); // GOTO
        tbl[7]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h1124, 14'h3123);
        tbl[8]  = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h1125, 14'h3124);
        tbl[9]  = mk(6'b010000, 11'h040, 8'h00, 5'h00, 13'h0040, 14'h0000); // CALL
        tbl[10] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0041, 14'h2040);
        tbl[11] = mk(6'b100000, 11'h000, 8'h00, 5'h00, 13'h1125, 14'h0000); // RETURN
        tbl[12] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h1126, 14'h3125);
        tbl[13] = mk(6'b000010, 11'h000, 8'h00, 5'h00, 13'h1127, 14'h0000); // skip
        tbl[14] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h1128, 14'h3127);
        tbl[15] = mk(6'b000000, 11'h000, 8'h00, 5'h00, 13'h1128, 14'h3127); // stall
        tbl[16] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h1129, 14'h3128);
        tbl[17] = mk(6'b000100, 11'h000, 8'h80, 5'h1F, 13'h1F80, 14'h0000); // PCL write
        tbl[18] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h1F81, 14'h3F80);
        tbl[19] = mk(6'b011111, 11'h7FF, 8'h80, 5'h00, 13'h07FF, 14'h0000); // call wins
        tbl[20] = mk(6'b110001, 11'h100, 8'h00, 5'h00, 13'h1F81, 14'h0000); // ret wins
        tbl[21] = mk(6'b001110, 11'h010, 8'h80, 5'h1F, 13'h1810, 14'h0000); // jump wins
        tbl[22] = mk(6'b000111, 11'h000, 8'h33, 5'h02, 13'h0233, 14'h0000); // pcl wins
        tbl[23] = mk(6'b000011, 11'h000, 8'h00, 5'h00, 13'h0234, 14'h0000); // skip wins
        tbl[24] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0235, 14'h2234);
        tbl[25] = mk(6'b000100, 11'h000, 8'hFF, 5'h1F, 13'h1FFF, 14'h0000);
        tbl[26] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0000, 14'h3FFF); // pc wrap
        tbl[27] = mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0001, 14'h2000);

        // Reset state
        #12;
        check("rst q_phase", 32'(q_phase), 32'd0);
        check("rst pc", 32'(pc), 32'd0);
        check("rst instr", 32'(instr_current), 32'd0);
        check("rst rd_en", 32'(pmem_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst rd_en", 32'(pmem_rd_en), 32'd1);
        check("post-rst addr", 32'(pmem_addr), 32'd0);
        // First instruction cycle executes the reset NOP.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("first-cycle instr q%0d", k + 2), 32'(instr_current), 32'd0);
            check($sformatf("first-cycle rd_en q%0d", k + 2), 32'(pmem_rd_en), 32'd0);
        end

        for (int i = 0; i < NVEC; i++) begin
            do_cycle(tbl[i], $sformatf("vec%0d", i));
        end

        // Controls asserted in Q1..Q3 and dropped before Q4 must do nothing.
        wait_phase(2'd0);
        call_en = 1; jump_en = 1; ret_en = 1; pcl_wr_en = 1;
        jump_lit = 11'h555; pcl_wr_data = 8'hAA; pclath = 5'h1F;
        wait_phase(2'd3);
        {ret_en, call_en, jump_en, pcl_wr_en, skip_en, incr_pc_en} = '0;
        check("off-Q4 pc held", 32'(pc), 32'h0001);
        check("off-Q4 instr held", 32'(instr_current), 32'h2000);
        do_cycle(mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0002, 14'h2001), "off-Q4 incr");

        // Stack wrap: 9 calls (returns p1=0x050, p2..p9=0x101..0x108), 9 returns.
        do_cycle(mk(6'b000100, 11'h000, 8'h50, 5'h00, 13'h0050, 14'h0000), "wrap setup");
        for (int i = 1; i <= 9; i++) begin
            do_cycle(mk(6'b010000, 11'(32'h100 + i), 8'h00, 5'h00, 13'(32'h100 + i), 14'h0000),
                     $sformatf("wrap call%0d", i));
        end
        for (int k = 1; k <= 9; k++) begin
            logic [12:0] exp_ret;
            exp_ret = (k == 9) ? 13'h0108 : 13'(32'h108 - (k - 1));
            do_cycle(mk(6'b100000, 11'h000, 8'h00, 5'h00, exp_ret, 14'h0000),
                     $sformatf("wrap ret%0d", k));
        end

        // Asynchronous reset pulse in the middle of Q2.
        do_cycle(mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0109, 14'h2108), "pre-rst incr");
        wait_phase(2'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst q_phase", 32'(q_phase), 32'd0);
        check("async rst pc", 32'(pc), 32'd0);
        check("async rst instr", 32'(instr_current), 32'd0);
        check("async rst rd_en", 32'(pmem_rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_cycle(mk(6'b000001, 11'h000, 8'h00, 5'h00, 13'h0001, 14'h2000), "post-rst incr");
        do_cycle(mk(6'b100000, 11'h000, 8'h00, 5'h00, 13'h0000, 14'h0000), "post-rst empty pop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
